// File: rtl/scan_pkg.sv
// Shared types and defaults for the scan chain driver.
package scan_pkg;

    localparam int DEFAULT_CHAIN_LEN = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load shift register: MSB shifts out, serial input enters at the LSB.
module scan_shift_reg
    import scan_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CHAIN_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             sin,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= din;
        else if (shift)
            q <= {q[WIDTH-2:0], sin};
    end

endmodule

// File: rtl/scan_chain_driver.sv
// Tester-side scan chain master: shifts a pattern in MSB first while unloading
// the previous chain contents, with an optional single capture cycle.
//
// state   | meaning
// IDLE    | waiting for start; chain clock gated off
// SHIFT   | CHAIN_LEN cycles with SE=1, CKE=1
// CAPTURE | one functional clock (SE=0, CKE=1)
// RESP    | response held until resp_ready
module scan_chain_driver
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pat_in,
    input  logic                 cap_en,
    output logic                 busy,
    output logic [CHAIN_LEN-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 SE,
    output logic                 SI,
    output logic                 CKE,
    input  logic                 SO
);

    localparam int CNT_W = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 cap_q;
    logic                 stim_load;
    logic                 chain_shift;
    logic [CHAIN_LEN-1:0] stim_q;
    logic [CHAIN_LEN-2:0] stim_rest_unused;
    logic [CHAIN_LEN-1:0] resp_q;
    logic [CHAIN_LEN-1:0] resp_next;

    assign stim_load   = (state == IDLE) && start;
    assign chain_shift = (state == SHIFT);
    assign resp_next   = {resp_q[CHAIN_LEN-2:0], SO};

    // The stimulus register shifts in zeros, so its MSB is exactly SI:
    // pattern bits during SHIFT and 0 everywhere else.
    assign {SI, stim_rest_unused} = stim_q;

    scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_stim (
        .clk   (CK),
        .rst   (RST),
        .load  (stim_load),
        .shift (chain_shift),
        .sin   (1'b0),
        .din   (pat_in),
        .q     (stim_q)
    );

    scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_resp (
        .clk   (CK),
        .rst   (RST),
        .load  (1'b0),
        .shift (chain_shift),
        .sin   (SO),
        .din   ('0),
        .q     (resp_q)
    );

    always_ff @(posedge CK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_q      <= 1'b0;
            SE         <= 1'b0;
            CKE        <= 1'b0;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        cap_q <= cap_en;
                        cnt   <= '0;
                        SE    <= 1'b1;
                        CKE   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        SE  <= 1'b0;
                        if (cap_q) begin
                            state <= CAPTURE;
                        end else begin
                            // Last SO bit arrives on this same edge.
                            state      <= RESP;
                            CKE        <= 1'b0;
                            busy       <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_data  <= resp_next;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    state      <= RESP;
                    CKE        <= 1'b0;
                    busy       <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_data  <= resp_q;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed bench for scan_chain_driver against a behavioural 8-flop scan chain.
module tb_scan_chain_driver;

    localparam int N = 8;

    logic         CK = 1'b0;
    logic         RST = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] pat_in = '0;
    logic         cap_en = 1'b0;
    logic         busy;
    logic [N-1:0] resp_data;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic         SE, SI, CKE, SO;

    // behavioural chain: flop 0 at SI end, flop N-1 drives SO
    logic [N-1:0] chain = '0;
    logic [N-1:0] d_in = '0;
    logic         preload_en = 1'b0;
    logic [N-1:0] preload_val = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CK = ~CK;

    always @(posedge CK) begin
        if (preload_en)
            chain <= preload_val;
        else if (CKE)
            chain <= SE ? {chain[N-2:0], SI} : d_in;
    end

    assign SO = chain[N-1];

    scan_chain_driver #(.CHAIN_LEN(N)) dut (
        .CK         (CK),
        .RST        (RST),
        .start      (start),
        .pat_in     (pat_in),
        .cap_en     (cap_en),
        .busy       (busy),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .SE         (SE),
        .SI         (SI),
        .CKE        (CKE),
        .SO         (SO)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Starts one operation and follows it until resp_valid (bounded).
    task automatic run_op(input string tag, input logic [N-1:0] pat, input logic cap,
                          input logic [N-1:0] exp_resp, input logic [N-1:0] exp_chain);
        int shift_cnt;
        int cap_cnt;
        int busy_bad;
        int lat;
        logic [N-1:0] si_word;
        shift_cnt = 0;
        cap_cnt   = 0;
        busy_bad  = 0;
        lat       = -1;
        si_word   = '0;
        pat_in = pat;
        cap_en = cap;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        pat_in = ~pat;
        cap_en = ~cap;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) begin
                lat = i + 1;
                break;
            end
            if (!busy) busy_bad++;
            if (SE && CKE) begin
                shift_cnt++;
                si_word = {si_word[N-2:0], SI};
            end
            if (!SE && CKE) cap_cnt++;
            tick();
        end
        if (lat < 0) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_latency"}, lat, cap ? N + 2 : N + 1);
        chk({tag, "_shift_cycles"}, shift_cnt, N);
        chk({tag, "_si_seq"}, si_word, pat);
        chk({tag, "_cap_cycles"}, cap_cnt, cap ? 1 : 0);
        chk({tag, "_busy_during"}, busy_bad, 0);
        chk({tag, "_busy_resp"}, busy, 0);
        chk({tag, "_resp_data"}, resp_data, exp_resp);
        chk({tag, "_chain"}, chain, exp_chain);
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk({tag, "_valid_drop"}, resp_valid, 0);
    endtask

    initial begin
        logic [N-1:0] held;
        int stable_bad;
        int stray_valid;

        // 1: reset in idle
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        chk("rst_se", SE, 0);
        chk("rst_si", SI, 0);
        chk("rst_cke", CKE, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_data", resp_data, 8'h00);
        tick();
        chk("idle_cke", CKE, 0);

        preload_en  = 1'b1;
        preload_val = 8'h3C;
        tick();
        preload_en  = 1'b0;

        // 2: basic load
        run_op("basic", 8'hA5, 1'b0, 8'h3C, 8'hA5);
        handshake("basic");

        // 3: back-to-back unload
        run_op("b2b", 8'h00, 1'b0, 8'hA5, 8'h00);
        handshake("b2b");

        // 4: capture, then unload the captured value
        d_in = 8'h96;
        run_op("cap", 8'hFF, 1'b1, 8'h00, 8'h96);
        handshake("cap");
        run_op("unload", 8'h5A, 1'b0, 8'h96, 8'h5A);

        // 5: backpressure with start pulsed in RESP
        held        = resp_data;
        stable_bad  = 0;
        start       = 1'b1;
        pat_in      = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!resp_valid || resp_data !== held || SE || CKE) stable_bad++;
        end
        chk("bp_stable", stable_bad, 0);
        resp_ready = 1'b1;
        tick();
        start      = 1'b0;
        resp_ready = 1'b0;
        chk("bp_valid_drop", resp_valid, 0);
        chk("bp_start_ignored_se", SE, 0);
        chk("bp_start_ignored_busy", busy, 0);
        chk("bp_data_hold", resp_data, 8'h96);
        tick();
        chk("bp_idle_cke", CKE, 0);

        // 6: reset at shift cycle 3
        pat_in = 8'h33;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_in_shift", SE, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_se", SE, 0);
        chk("mid_cke", CKE, 0);
        chk("mid_busy", busy, 0);
        stray_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) stray_valid++;
            tick();
        end
        chk("mid_no_resp", stray_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
